// File: rtl/soc_ifc_pkg.sv
// rtl/soc_ifc_pkg.sv - mailbox SRAM widths, arbiter state encoding and default burst limit
package soc_ifc_pkg;

  localparam int CPTRA_MBOX_ADDR_W          = 15;
  localparam int CPTRA_MBOX_DATA_W          = 32;
  localparam int CPTRA_MBOX_ECC_W           = 7;
  localparam int CPTRA_MBOX_DATA_AND_ECC_W  = CPTRA_MBOX_DATA_W + CPTRA_MBOX_ECC_W;
  localparam int MBOX_SRAM_ARB_MAX_BURST    = 8;

  // The state names the requester that was granted most recently.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } mbox_sram_arb_state_e;

endpackage

// File: rtl/mbox_sram_arb_rr.sv
// rtl/mbox_sram_arb_rr.sv - owner FSM and burst counter producing a same-cycle one-hot grant
module mbox_sram_arb_rr
  import soc_ifc_pkg::*;
#(
  parameter int MAX_BURST = MBOX_SRAM_ARB_MAX_BURST
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] gnt
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  mbox_sram_arb_state_e state;
  logic [CNT_W-1:0]     burst_cnt;

  // Contention keeps the owner until its burst is spent; a lone requester always wins.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      unique case (valid)
        2'b01: gnt = 2'b01;
        2'b10: gnt = 2'b10;
        2'b11: begin
          unique case (state)
            OWN0:    gnt = (burst_cnt < MAX_CNT) ? 2'b01 : 2'b10;
            OWN1:    gnt = (burst_cnt < MAX_CNT) ? 2'b10 : 2'b01;
            default: gnt = 2'b01;
          endcase
        end
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else if (gnt == 2'b00) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else if ((gnt[0] && state == OWN0) || (gnt[1] && state == OWN1)) begin
      if (burst_cnt < MAX_CNT) begin
        burst_cnt <= burst_cnt + ONE_CNT;
      end
    end else begin
      state     <= gnt[0] ? OWN0 : OWN1;
      burst_cnt <= ONE_CNT;
    end
  end

endmodule

// File: rtl/mbox_sram_arb.sv
// rtl/mbox_sram_arb.sv - two-requester mailbox SRAM arbiter (optional MBOX_SRAM_ARB_PERF_EN counters)
module mbox_sram_arb
  import soc_ifc_pkg::*;
#(
  parameter int ADDR_W    = CPTRA_MBOX_ADDR_W,
  parameter int DATA_W    = CPTRA_MBOX_DATA_AND_ECC_W,
  parameter int MAX_BURST = MBOX_SRAM_ARB_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              mbox_sram_cs,
  output logic              mbox_sram_we,
  output logic [ADDR_W-1:0] mbox_sram_addr,
  output logic [DATA_W-1:0] mbox_sram_wdata,
  input  logic [DATA_W-1:0] mbox_sram_rdata
`ifdef MBOX_SRAM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_gnt0_cnt,
  output logic [31:0]       perf_gnt1_cnt,
  output logic [31:0]       perf_stall1_cnt
`endif
);

  logic [1:0] gnt;
  logic [1:0] rd_pend;

  mbox_sram_arb_rr #(
    .MAX_BURST (MAX_BURST)
  ) u_rr (
    .clk   (clk),
    .rst   (rst),
    .valid ({req1_valid, req0_valid}),
    .gnt   (gnt)
  );

  assign req0_ready   = gnt[0];
  assign req1_ready   = gnt[1];
  assign mbox_sram_cs = gnt[0] | gnt[1];

  always_comb begin
    mbox_sram_we    = 1'b0;
    mbox_sram_addr  = '0;
    mbox_sram_wdata = '0;
    if (gnt[0]) begin
      mbox_sram_we    = req0_we;
      mbox_sram_addr  = req0_addr;
      mbox_sram_wdata = req0_wdata;
    end else if (gnt[1]) begin
      mbox_sram_we    = req1_we;
      mbox_sram_addr  = req1_addr;
      mbox_sram_wdata = req1_wdata;
    end
  end

  // One flag per requester so alternating reads return without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= 2'b00;
    end else begin
      rd_pend <= {gnt[1] & ~req1_we, gnt[0] & ~req0_we};
    end
  end

  assign req0_rvalid = rd_pend[0];
  assign req1_rvalid = rd_pend[1];
  assign req0_rdata  = mbox_sram_rdata;
  assign req1_rdata  = mbox_sram_rdata;

`ifdef MBOX_SRAM_ARB_PERF_EN
  logic [31:0] perf_gnt0_q;
  logic [31:0] perf_gnt1_q;
  logic [31:0] perf_stall1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_gnt0_q   <= '0;
      perf_gnt1_q   <= '0;
      perf_stall1_q <= '0;
    end else begin
      if (gnt[0] && perf_gnt0_q != 32'hFFFF_FFFF) begin
        perf_gnt0_q <= perf_gnt0_q + 32'd1;
      end
      if (gnt[1] && perf_gnt1_q != 32'hFFFF_FFFF) begin
        perf_gnt1_q <= perf_gnt1_q + 32'd1;
      end
      if (req1_valid && !gnt[1] && perf_stall1_q != 32'hFFFF_FFFF) begin
        perf_stall1_q <= perf_stall1_q + 32'd1;
      end
    end
  end

  assign perf_gnt0_cnt   = perf_gnt0_q;
  assign perf_gnt1_cnt   = perf_gnt1_q;
  assign perf_stall1_cnt = perf_stall1_q;
`endif

endmodule

// File: doc/mbox_sram_arb.md
MBOX_SRAM_ARB -- requirements
Module: mbox_sram_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default CPTRA_MBOX_ADDR_W: SRAM word address width.
REQ-002 SHALL have parameter DATA_W, default CPTRA_MBOX_DATA_AND_ECC_W: SRAM data plus ECC width.
REQ-003 SHALL have parameter MAX_BURST, default 8: maximum consecutive grants to one requester while the other requester waits.
REQ-004 SHALL have port clk, input, 1: single clock.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports reqN_valid, reqN_ready, input/output, 1 each, N=0,1: per-requester access handshake; requester 0 is uC, requester 1 is SoC.
REQ-007 SHALL have ports reqN_we, input, 1; reqN_addr, input, ADDR_W; reqN_wdata, input, DATA_W: access attributes.
REQ-008 SHALL have ports reqN_rvalid, output, 1; reqN_rdata, output, DATA_W: read response.
REQ-009 SHALL have ports mbox_sram_cs, mbox_sram_we, output, 1; mbox_sram_addr, output, ADDR_W; mbox_sram_wdata, output, DATA_W; mbox_sram_rdata, input, DATA_W: SRAM port with 1-cycle read latency.

Function
REQ-010 SHALL transfer an access only when reqN_valid and reqN_ready are both high; reqN_ready SHALL be combinational on the valid inputs and the arbiter state.
REQ-011 SHALL assert at most one reqN_ready per cycle, and SHALL drive mbox_sram_cs high exactly in the cycles where a transfer occurs.
REQ-012 SHALL use an FSM with states IDLE, OWN0 and OWN1; the state names the requester that was last granted.
REQ-013 When exactly one requester is valid, that requester SHALL be granted in the same cycle, from any state.
REQ-014 When both requesters are valid, the current owner SHALL keep the grant while its burst counter is below MAX_BURST; otherwise the non-owner SHALL be granted.
REQ-015 When both requesters are valid in IDLE, requester 0 SHALL be granted.
REQ-016 The burst counter SHALL be $clog2(MAX_BURST+1) bits wide.
REQ-017 The burst counter SHALL reset to 1 when ownership changes or the state leaves IDLE.
REQ-018 The burst counter SHALL increment on each same-owner grant and saturate at MAX_BURST.
REQ-019 With no valid request, the FSM SHALL return to IDLE.
REQ-020 A read transfer SHALL produce reqN_rvalid exactly one cycle later, to the granted requester only, with reqN_rdata = mbox_sram_rdata.
REQ-021 Both reqN_rdata outputs SHALL carry mbox_sram_rdata unconditionally.
REQ-022 Back-to-back reads, including reads that alternate requesters, SHALL sustain one response per cycle with no bubbles.
REQ-023 A write transfer SHALL produce no rvalid.
REQ-024 mbox_sram_addr and mbox_sram_wdata SHALL be muxed from the granted requester, and SHALL be zero when cs is low.

Reset
REQ-025 While rst is high: FSM = IDLE, burst counter = 0, pending-read flags = 0.
REQ-026 While rst is high, all ready, rvalid, cs and we outputs SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL drop any pending read response, and SHALL generate no rvalid in the cycle after reset deasserts.

Configuration
REQ-028 When MBOX_SRAM_ARB_PERF_EN is defined, the block SHALL add outputs perf_gnt0_cnt, perf_gnt1_cnt and perf_stall1_cnt, each 32 bits.
REQ-029 perf_gnt0_cnt and perf_gnt1_cnt SHALL count grants per requester; perf_stall1_cnt SHALL count cycles with req1_valid high and req1_ready low.
REQ-030 The performance counters SHALL saturate at 32'hFFFF_FFFF and SHALL reset to 0.
REQ-031 When MBOX_SRAM_ARB_PERF_EN is not defined, the performance ports and counters SHALL be absent and the rest of the behaviour SHALL be unchanged.

Structure
REQ-032 SHALL place the FSM state enum mbox_sram_arb_state_e and the default MAX_BURST constant in soc_ifc_pkg.
REQ-033 SHALL use a single sub-module, mbox_sram_arb_rr, holding the owner FSM and burst counter and producing the grant vector; the datapath mux and response routing SHALL live in the top module.

Verification
REQ-034 Only req0_valid; write addr 0x10, data 0x55, then read 0x10 -> cs high in both cycles; req0_rvalid one cycle after the read with rdata 0x55; req1_rvalid stays 0.
REQ-035 Both valid continuously from IDLE, MAX_BURST=8 -> grant sequence 8x req0, 8x req1, 8x req0; no idle cycles on cs.
REQ-036 Alternating single reads req0 @0x1, then req1 @0x2 on consecutive cycles -> req0_rvalid then req1_rvalid on consecutive cycles, each with its own data.
REQ-037 rst asserted the cycle after a req1 read grant -> no req1_rvalid; all outputs 0 while rst is high; first grant after reset goes to req0 when both are valid.
REQ-038 With MBOX_SRAM_ARB_PERF_EN and req1 held valid while req0 owns 8 grants -> perf_stall1_cnt = 8 and perf_gnt0_cnt = 8.
REQ-039 Counter saturation: force a performance counter to 32'hFFFF_FFFE, then 3 grants -> counter holds 32'hFFFF_FFFF.
